// File: rtl/reg_word_serializer_pkg.sv
// rtl/reg_word_serializer_pkg.sv - shared FSM encodings and counter sizing for the word serializer
//
// Purpose: FSM state encodings and the bit-counter width helper used by
// reg_word_serializer and its hold register. No datapath constants live here.
package reg_word_serializer_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Bits needed to count 0..w-1. A one-bit word still gets a one-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/reg_word_serializer_param_register.sv
// rtl/reg_word_serializer_param_register.sv - generic WIDTH-bit ld register
//
// Purpose: parallel-load register, the parameterised form of the fixed-width
// ld registers. It holds its value until ld is asserted at a rising edge.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, clears out to zero
//   ld   - load strobe
//   in   - WIDTH-bit data captured when ld is high
//   out  - WIDTH-bit registered contents
module param_register
  import reg_word_serializer_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else if (ld) begin
      out <= in;
    end
  end

endmodule

// File: rtl/reg_word_serializer.sv
// rtl/reg_word_serializer.sv - parallel word to valid/ready serial bit stream
//
// Purpose: accepts WIDTH-bit words on a load strobe and sends them one bit per
// accepted cycle. A one-entry hold buffer takes the next word while the current
// one shifts, so back-to-back words stream without bubble cycles.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   ld        - load strobe, word accepted when ld && in_ready
//   in        - parallel word, sampled on accept
//   in_ready  - hold buffer free and not in reset (combinational)
//   ser_out   - serial data bit
//   ser_valid - ser_out carries a valid bit
//   ser_last  - current bit is the final bit of its word
//   ser_ready - sink accepts the bit when ser_valid && ser_ready
//   busy      - a bit is being presented or a word is waiting in hold
module reg_word_serializer
  import reg_word_serializer_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] in,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic             busy
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  logic             state_q;
  logic             state_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] hold_q;
  logic [CW-1:0]    count_q;
  logic             last_q;
  logic             hold_full_q;

  logic accept;
  logic at_last;
  logic bit_hs;
  logic finish;
  logic load_from_in;
  logic load_from_hold;
  logic do_shift;
  logic hold_ld;

  assign in_ready = !rst && !hold_full_q;
  assign accept   = ld && in_ready;
  assign at_last  = (count_q == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave SHIFT only when the last bit goes out and nothing
  // (neither the hold buffer nor a same-cycle load) is ready to follow it.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (accept) begin
        state_d = ST_SHIFT;
      end
    end else begin
      if (finish && !hold_full_q && !accept) begin
        state_d = ST_IDLE;
      end
    end
  end

  // Output / control decode
  always_comb begin
    ser_valid      = (state_q == ST_SHIFT);
    bit_hs         = 1'b0;
    finish         = 1'b0;
    load_from_in   = 1'b0;
    load_from_hold = 1'b0;
    do_shift       = 1'b0;
    hold_ld        = 1'b0;
    if (state_q == ST_IDLE) begin
      load_from_in = accept;
    end else begin
      bit_hs         = ser_ready;
      finish         = ser_ready && at_last;
      do_shift       = ser_ready && !at_last;
      // The held word wins over a new load; in_ready is low while hold is full
      // so accept cannot also be set here.
      load_from_hold = finish && hold_full_q;
      load_from_in   = finish && !hold_full_q && accept;
      // A word arriving while the current one is still mid-flight parks in hold.
      hold_ld        = accept && !finish;
    end
  end

  // Hold buffer
  param_register #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk (clk),
    .rst (rst),
    .ld  (hold_ld),
    .in  (in),
    .out (hold_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full_q <= 1'b0;
    end else if (hold_ld) begin
      hold_full_q <= 1'b1;
    end else if (load_from_hold) begin
      hold_full_q <= 1'b0;
    end
  end

  // Shift register, bit counter and registered last flag
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else if (load_from_hold) begin
      shift_q <= hold_q;
      count_q <= '0;
      last_q  <= (WIDTH == 1);
    end else if (load_from_in) begin
      shift_q <= in;
      count_q <= '0;
      last_q  <= (WIDTH == 1);
    end else if (do_shift) begin
      shift_q <= MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
      count_q <= count_q + CW'(1);
      last_q  <= ((count_q + CW'(1)) == CNT_LAST);
    end else if (finish) begin
      // Word done with nothing behind it: park the line at zero.
      shift_q <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end
  end

  assign ser_out  = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
  assign ser_last = last_q;
  assign busy     = ser_valid || hold_full_q;

endmodule
